// File: rtl/cmsdk_uart_cmd_ctrl.sv
// UART (8N1) receiver for the MCU StdOut stream with an escape-coded command decoder.
// Non-command bytes are passed through; command bytes drive bench control outputs.
module cmsdk_uart_cmd_ctrl #(
  parameter int          BAUD_DIV = 16,
  parameter logic [7:0]  ESC_CODE = 8'h1B
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       RXD,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       FRAME_ERR,
  output logic       DEBUG_TESTER_ENABLE,
  output logic       SIMULATIONEND,
  output logic [7:0] AUXCTRL
);

  // state     | meaning
  // R_IDLE    | line idle, waiting for a start edge
  // R_START   | half a bit into the start bit, confirm it is still low
  // R_DATA    | sampling the eight data bits at bit centres
  // R_STOP    | sampling the stop bit
  // R_BREAK   | bad stop bit seen, wait for the line to return high
  // C_NORM    | decoder passes bytes through
  // C_CMD     | escape seen, next byte is a command
  // C_AUX     | next byte loads AUXCTRL

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_t;
  typedef enum logic [1:0] {C_NORM, C_CMD, C_AUX} cmd_state_t;

  logic            rx_meta, rxs;
  rx_state_t       rx_state, rx_state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      bit_idx, bit_idx_nxt;
  logic [7:0]      shreg, shreg_nxt;
  logic            byte_stb, byte_stb_nxt;
  logic            ferr_stb, ferr_stb_nxt;

  cmd_state_t      cmd_state, cmd_state_nxt;
  logic [7:0]      rx_data_nxt;
  logic            rx_valid_nxt;
  logic            dte_nxt, simend_nxt;
  logic [7:0]      aux_nxt;

  // Synchroniser presets to the idle line level so reset release never looks like a start bit.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= RXD;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rx_state <= R_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      byte_stb <= 1'b0;
      ferr_stb <= 1'b0;
    end else begin
      rx_state <= rx_state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shreg    <= shreg_nxt;
      byte_stb <= byte_stb_nxt;
      ferr_stb <= ferr_stb_nxt;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    cnt_nxt      = cnt;
    bit_idx_nxt  = bit_idx;
    shreg_nxt    = shreg;
    byte_stb_nxt = 1'b0;
    ferr_stb_nxt = 1'b0;
    case (rx_state)
      R_IDLE: begin
        if (!rxs) begin
          cnt_nxt      = HALF_LOAD;
          rx_state_nxt = R_START;
        end
      end
      R_START: begin
        if (cnt == '0) begin
          if (rxs) begin
            rx_state_nxt = R_IDLE;
          end else begin
            rx_state_nxt = R_DATA;
            bit_idx_nxt  = 3'd0;
            cnt_nxt      = FULL_LOAD;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      R_DATA: begin
        if (cnt == '0) begin
          shreg_nxt[bit_idx] = rxs;
          cnt_nxt            = FULL_LOAD;
          if (bit_idx == 3'd7) rx_state_nxt = R_STOP;
          else                 bit_idx_nxt  = bit_idx + 3'd1;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      R_STOP: begin
        if (cnt == '0) begin
          if (rxs) begin
            byte_stb_nxt = 1'b1;
            rx_state_nxt = R_IDLE;
          end else begin
            ferr_stb_nxt = 1'b1;
            rx_state_nxt = R_BREAK;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      R_BREAK: begin
        if (rxs) rx_state_nxt = R_IDLE;
      end
      default: rx_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      cmd_state           <= C_NORM;
      RX_DATA             <= '0;
      RX_VALID            <= 1'b0;
      FRAME_ERR           <= 1'b0;
      DEBUG_TESTER_ENABLE <= 1'b0;
      SIMULATIONEND       <= 1'b0;
      AUXCTRL             <= '0;
    end else begin
      cmd_state           <= cmd_state_nxt;
      RX_DATA             <= rx_data_nxt;
      RX_VALID            <= rx_valid_nxt;
      FRAME_ERR           <= ferr_stb;
      DEBUG_TESTER_ENABLE <= dte_nxt;
      SIMULATIONEND       <= simend_nxt;
      AUXCTRL             <= aux_nxt;
    end
  end

  // shreg stays stable for half a bit after byte_stb, so it is consumed directly.
  always_comb begin
    cmd_state_nxt = cmd_state;
    rx_data_nxt   = RX_DATA;
    rx_valid_nxt  = 1'b0;
    dte_nxt       = DEBUG_TESTER_ENABLE;
    simend_nxt    = SIMULATIONEND;
    aux_nxt       = AUXCTRL;
    if (byte_stb) begin
      case (cmd_state)
        C_NORM: begin
          if (shreg == ESC_CODE) begin
            cmd_state_nxt = C_CMD;
          end else begin
            rx_data_nxt  = shreg;
            rx_valid_nxt = 1'b1;
          end
        end
        C_CMD: begin
          cmd_state_nxt = C_NORM;
          if (shreg == ESC_CODE)   cmd_state_nxt = C_CMD;
          else if (shreg == 8'h11) dte_nxt       = 1'b1;
          else if (shreg == 8'h12) dte_nxt       = 1'b0;
          else if (shreg == 8'h10) cmd_state_nxt = C_AUX;
          else if (shreg == 8'h04) simend_nxt    = 1'b1;
        end
        C_AUX: begin
          aux_nxt       = shreg;
          cmd_state_nxt = C_NORM;
        end
        default: cmd_state_nxt = C_NORM;
      endcase
    end
  end

endmodule

// File: doc/cmsdk_uart_cmd_ctrl.md
Name: cmsdk_uart_cmd_ctrl

Overview:
- Bench-side controller that receives the MCU's StdOut UART stream (8N1) on one pin and turns escape-coded command bytes into control outputs.
- Controls the debug-tester enable, the simulation-end flag and an 8-bit auxiliary control register.
- Passes all non-command bytes through as a byte stream for logging.
- Sits between UART0 TXD (P1[1]) and the debug tester / bench end-of-test logic.

Parameters:
- BAUD_DIV, 16, CLK cycles per UART bit; even, minimum 4.
- ESC_CODE, 8'h1B, escape byte that introduces a command.

Ports:
- CLK  input  1  bench/peripheral clock.
- RESETn  input  1  asynchronous active-low reset.
- RXD  input  1  serial input, idle high, 8N1, LSB first.
- RX_DATA  output  8  last pass-through byte.
- RX_VALID  output  1  one-cycle pulse when RX_DATA is updated.
- FRAME_ERR  output  1  one-cycle pulse on a bad stop bit.
- DEBUG_TESTER_ENABLE  output  1  enables the debug tester drive onto GPIO.
- SIMULATIONEND  output  1  sticky end-of-simulation flag.
- AUXCTRL  output  8  auxiliary control register.

Behaviour:
- Reset (RESETn low, asynchronous): all outputs 0; receiver in R_IDLE; command decoder in C_NORM; synchroniser flops preset to 1. Reset asserted mid-frame aborts the frame; no pulse is produced.
- RXD passes through a 2-flop synchroniser (rxs); all receiver decisions use rxs.
- Receiver FSM:
  - R_IDLE: on rxs==0, load counter with BAUD_DIV/2-1 and go to R_START.
  - R_START: when counter==0, sample rxs. If 1 (glitch), return to R_IDLE with no output. If 0, go to R_DATA with bit index 0 and counter BAUD_DIV-1.
  - R_DATA: each time counter==0, shift rxs into bit[idx] (LSB first) and reload the counter. After bit 7, go to R_STOP.
  - R_STOP: at counter==0, sample rxs.
    - rxs==1: hand the byte to the decoder and return to R_IDLE.
    - rxs==0: pulse FRAME_ERR, discard the byte and go to R_BREAK.
  - R_BREAK: wait until rxs==1, then go to R_IDLE. This guarantees no re-trigger inside a break condition.
- Latency: let t0 be the CLK edge at which RXD is first sampled low. The byte is handed to the decoder at t0+2+BAUD_DIV/2+9*BAUD_DIV. RX_VALID (when passed through) is high during the following cycle. With BAUD_DIV=16 that is t0+155.
- A new start bit is accepted from the cycle after the stop-bit sample. Back-to-back frames with no idle gap must be received without loss.
- Decoder FSM, one byte per step:
  - C_NORM: ESC_CODE goes to C_CMD and is not output. Any other byte is output (RX_DATA updated, RX_VALID pulse).
  - C_CMD:
    - 8'h11: DEBUG_TESTER_ENABLE=1, go to C_NORM.
    - 8'h12: DEBUG_TESTER_ENABLE=0, go to C_NORM.
    - 8'h10: go to C_AUX.
    - 8'h04: SIMULATIONEND=1 (sticky until reset), go to C_NORM.
    - ESC_CODE: stay in C_CMD, no output.
    - Any other value: discarded, no output, go to C_NORM.
  - C_AUX: any byte, including ESC_CODE, is loaded into AUXCTRL; go to C_NORM; no output.
- Control outputs update in the same cycle RX_VALID would have pulsed.
- A frame error does not change decoder state: an ESC followed by a corrupt byte leaves the decoder in C_CMD.
- Bytes continue to be decoded after SIMULATIONEND is set.
- RX_VALID and FRAME_ERR are never high in the same cycle. Neither is ever high for two consecutive cycles.

Test Plan:
- Reset, then send 0x41 at BAUD_DIV=16 -> exactly one RX_VALID pulse with RX_DATA=0x41, 155 cycles after the first low sample; all other outputs stay 0.
- Send 0x1B,0x11, then 0x55, then 0x1B,0x12 -> DEBUG_TESTER_ENABLE rises after the second byte; one RX_VALID with 0x55 only; DEBUG_TESTER_ENABLE falls after the fifth byte.
- Send 0x1B,0x10,0x1B -> AUXCTRL=0x1B, no RX_VALID; then 0x1B,0x1B,0x04 -> SIMULATIONEND=1, no RX_VALID.
- Frame with stop bit 0 (data 0xA5), RXD held low for 3 bit times, then a valid 0x5A -> one FRAME_ERR pulse, no RX_VALID for 0xA5, RX_VALID with 0x5A.
- RXD low pulse of BAUD_DIV/4 cycles -> no output pulses; receiver back in idle; a following 0x33 is received correctly.
- Assert RESETn mid-frame during bit 4 of 0x1B,0x11 traffic -> all outputs 0 immediately, no pulses; the next full 0x1B,0x11 sequence sets DEBUG_TESTER_ENABLE=1.
